// File: rtl/calc_seq_player.sv
// rtl/calc_seq_player.sv - autonomous program replayer and checker for the calc block
//
// Purpose: holds a small program of (op, operand, expected) entries. On i_start it
// clears the calc accumulator, then for every entry presents op/operand, strobes
// btnd, waits, and compares i_led with the expected value, counting passes/fails.
//
// Optional feature macro: CALC_PLAYER_STOP_ON_FAIL_EN (first mismatch ends the run).
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_start                        run request (accepted only when idle/done)
//   i_load_en/addr/op/operand/     program entry write port (ignored while running)
//   i_load_expect/last
//   o_btnl/o_btnc/o_btnr, o_sw     op select and operand to calc
//   o_btnu, o_btnd                 accumulator clear / accumulate strobe
//   i_led                          calc result
//   o_busy, o_done                 run in progress / last run finished (level)
//   o_pass_cnt, o_fail_cnt         per-entry results of the last run
//   o_first_fail                   index of first mismatch (valid when fail count != 0)

module calc_seq_player #(
   parameter int DEPTH  = 16,
   parameter int SETTLE = 4,
   parameter int PULSE  = 2,
   parameter int CLR    = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_start,
   input  logic          i_load_en,
   input  logic [AW-1:0] i_load_addr,
   input  logic [2:0]    i_load_op,
   input  logic [15:0]   i_load_operand,
   input  logic [15:0]   i_load_expect,
   input  logic          i_load_last,
   output logic          o_btnl,
   output logic          o_btnc,
   output logic          o_btnr,
   output logic          o_btnu,
   output logic          o_btnd,
   output logic [15:0]   o_sw,
   input  logic [15:0]   i_led,
   output logic          o_busy,
   output logic          o_done,
   output logic [CW-1:0] o_pass_cnt,
   output logic [CW-1:0] o_fail_cnt,
   output logic [AW-1:0] o_first_fail
);

   localparam int TW = 16;

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_SETUP, S_STROBE, S_WAIT, S_CHECK, S_DONE
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [TW-1:0] r_tmr;
   logic [AW-1:0] r_idx;
   logic [CW-1:0] r_len;
   logic [CW-1:0] r_pass;
   logic [CW-1:0] r_fail;
   logic [AW-1:0] r_first;

   logic [2:0]    r_mem_op  [DEPTH];
   logic [15:0]   r_mem_sw  [DEPTH];
   logic [15:0]   r_mem_exp [DEPTH];

   logic          r_btnl, r_btnc, r_btnr, r_btnu, r_btnd, r_busy, r_done;
   logic [15:0]   r_sw;

   logic          w_idle;
   logic          w_accept;
   logic          w_match;
   logic          w_last;
   logic          w_tmr_end;
   logic [2:0]    w_op;
   logic [15:0]   w_sw;
   logic          w_btnu;
   logic          w_btnd;
   logic          w_busy;
   logic          w_done;

   assign w_idle   = (r_state == S_IDLE) || (r_state == S_DONE);
   assign w_accept = w_idle && i_start;
   assign w_match  = (i_led == r_mem_exp[r_idx]);
   // r_len is at least 1 whenever a run is active, so len-1 never underflows there.
   assign w_last   = ({1'b0, r_idx} == (r_len - CW'(1)));

   // The timed states share one counter that restarts on every state change.
   always_comb begin
      w_tmr_end = 1'b0;
      case (r_state)
         S_CLEAR:  w_tmr_end = (r_tmr == TW'(CLR - 1));
         S_SETUP:  w_tmr_end = (r_tmr == TW'(SETTLE - 1));
         S_STROBE: w_tmr_end = (r_tmr == TW'(PULSE - 1));
         S_WAIT:   w_tmr_end = (r_tmr == TW'(SETTLE - 1));
         default:  w_tmr_end = 1'b0;
      endcase
   end

   // Program memory carries no reset so contents survive a mid-run reset.
   always_ff @(posedge i_clk) begin
      if (i_load_en && w_idle) begin
         r_mem_op[i_load_addr]  <= i_load_op;
         r_mem_sw[i_load_addr]  <= i_load_operand;
         r_mem_exp[i_load_addr] <= i_load_expect;
      end
   end

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               w_next = (r_len == '0) ? S_DONE : S_CLEAR;
            end
         end
         S_CLEAR:  if (w_tmr_end) w_next = S_SETUP;
         S_SETUP:  if (w_tmr_end) w_next = S_STROBE;
         S_STROBE: if (w_tmr_end) w_next = S_WAIT;
         S_WAIT:   if (w_tmr_end) w_next = S_CHECK;
         S_CHECK: begin
            if (w_last) begin
               w_next = S_DONE;
`ifdef CALC_PLAYER_STOP_ON_FAIL_EN
            end else if (!w_match) begin
               w_next = S_DONE;
`endif
            end else begin
               w_next = S_SETUP;
            end
         end
         default:  w_next = S_IDLE;
      endcase
   end

   // Output decode from the current state; registered below, which gives the
   // one-cycle lag between start acceptance and busy/btnu.
   always_comb begin
      w_op   = 3'b000;
      w_sw   = 16'h0000;
      w_btnu = 1'b0;
      w_btnd = 1'b0;
      w_busy = !w_idle;
      w_done = (r_state == S_DONE);
      case (r_state)
         S_CLEAR: w_btnu = 1'b1;
         S_SETUP, S_WAIT, S_CHECK: begin
            w_op = r_mem_op[r_idx];
            w_sw = r_mem_sw[r_idx];
         end
         S_STROBE: begin
            w_op   = r_mem_op[r_idx];
            w_sw   = r_mem_sw[r_idx];
            w_btnd = 1'b1;
         end
         default: begin
            w_op = 3'b000;
         end
      endcase
   end

   // Timer, index, length and result counters
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tmr   <= '0;
         r_idx   <= '0;
         r_len   <= '0;
         r_pass  <= '0;
         r_fail  <= '0;
         r_first <= '0;
      end else begin
         if (w_idle || (w_next != r_state)) begin
            r_tmr <= '0;
         end else begin
            r_tmr <= r_tmr + TW'(1);
         end

         if (i_load_en && w_idle && i_load_last) begin
            r_len <= CW'(i_load_addr) + CW'(1);
         end

         if (w_accept) begin
            r_idx   <= '0;
            r_pass  <= '0;
            r_fail  <= '0;
            r_first <= '0;
         end else if (r_state == S_CHECK) begin
            if (w_match) begin
               r_pass <= r_pass + CW'(1);
            end else begin
               r_fail <= r_fail + CW'(1);
               if (r_fail == '0) begin
                  r_first <= r_idx;
               end
            end
            if (w_next == S_SETUP) begin
               r_idx <= r_idx + AW'(1);
            end
         end
      end
   end

   // Output registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_btnl <= 1'b0;
         r_btnc <= 1'b0;
         r_btnr <= 1'b0;
         r_sw   <= '0;
         r_btnu <= 1'b0;
         r_btnd <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         {r_btnl, r_btnc, r_btnr} <= w_op;
         r_sw   <= w_sw;
         r_btnu <= w_btnu;
         r_btnd <= w_btnd;
         r_busy <= w_busy;
         // An accepted start drops done even when restarting straight from DONE.
         r_done <= w_accept ? 1'b0 : w_done;
      end
   end

   assign o_btnl       = r_btnl;
   assign o_btnc       = r_btnc;
   assign o_btnr       = r_btnr;
   assign o_sw         = r_sw;
   assign o_btnu       = r_btnu;
   assign o_btnd       = r_btnd;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_pass_cnt   = r_pass;
   assign o_fail_cnt   = r_fail;
   assign o_first_fail = r_first;

endmodule

// File: doc/calc_seq_player.md
# calc_seq_player

Autonomous stimulus sequencer and checker that drives the calculator's button/switch inputs and reads back its LED output. Holds a small program of (operation, operand, expected result) entries. On `start` it clears the accumulator, then replays each entry: it presents the op and operand, strobes `btnd`, waits, and compares `led` against the expected value. It sits on the board side of the calc interface, as the producer of `btnl/btnc/btnr/btnu/btnd/sw` and the consumer of `led`, and allows on-target self-test without a host.

## Interface
- `DEPTH`, 16: program entries; power of two, 2..256. `AW = $clog2(DEPTH)`, `CW = AW+1`.
- `SETTLE`, 4: cycles the inputs are held before the strobe, and cycles waited after it; must be ≥1.
- `PULSE`, 2: `btnd` high time in cycles, ≥1.
- `CLR`, 2: `btnu` high time at run start, ≥1.

Ports:
- `clk`  in  1  system clock; all state is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request, sampled in IDLE/DONE.
- `load_en`  in  1  write one program entry this cycle; ignored while `busy`.
- `load_addr`  in  AW  entry index.
- `load_op`  in  3  {btnl,btnc,btnr} op code.
- `load_operand`  in  16  value for `sw`.
- `load_expect`  in  16  expected `led` after the strobe.
- `load_last`  in  1  this entry ends the program.
- `btnl`, `btnc`, `btnr`  out  1  op select to calc.
- `btnu`  out  1  calc accumulator clear.
- `btnd`  out  1  calc accumulate strobe.
- `sw`  out  16  operand to calc.
- `led`  in  16  calc result.
- `busy`  out  1  run in progress.
- `done`  out  1  last run finished; level, held until next accepted `start`.
- `pass_cnt`, `fail_cnt`  out  CW  entry results for the last run.
- `first_fail`  out  AW  index of first mismatch; valid when `fail_cnt != 0`.

## Operation
- Program memory: register array, not reset. Length register `len` (CW bits) resets to 0. A load with `load_last=1` sets `len = load_addr+1`. Loads with `load_last=0` do not change `len`.
- FSM states: IDLE, CLEAR, SETUP, STROBE, WAIT, CHECK, DONE.
- IDLE/DONE + `start`:
  - Clear `pass_cnt`, `fail_cnt`, `first_fail`, `done`, and the index.
  - If `len==0`: go directly to DONE, with `done=1` the next cycle and counts 0.
  - Otherwise: go to CLEAR.
- CLEAR: `btnu=1` for CLR cycles, then SETUP.
- SETUP: drive `{btnl,btnc,btnr}=op[idx]` and `sw=operand[idx]` for SETTLE cycles, then STROBE.
- STROBE: `btnd=1` for PULSE cycles, then WAIT.
- WAIT: SETTLE cycles with `btnd=0`, then CHECK.
- CHECK (1 cycle): compare `led` to `expect[idx]`.
  - Match: increment `pass_cnt`.
  - Mismatch: increment `fail_cnt`; if this is the first mismatch, latch `first_fail=idx`.
  - If `idx==len-1`, go to DONE; otherwise `idx++` and go to SETUP.
- Op and sw are held constant from SETUP entry through CHECK, and return to 0 in IDLE/DONE/CLEAR.
- `start` while busy is ignored. `load_en` while busy is ignored; running entries are never modified.
- Counters cannot wrap: the maximum is DEPTH, which fits in CW bits.

## Timing
- Reset values: all outputs 0; FSM in IDLE; `len=0`; `idx=0`.
- Reset asserted mid-run: all of the above immediately (asynchronous); `btnd`/`btnu` drop without completing the pulse. Memory contents are retained.
- `start` accepted at edge N: `busy=1` and `btnu=1` from edge N+1.
- Cycles per entry: SETTLE + PULSE + SETTLE + 1 (11 at defaults).
- Run length: 1 + CLR + len·(2·SETTLE+PULSE+1) cycles from `start` to `done` rising. `busy` falls on the same edge that `done` rises.
- `led` is sampled combinationally at the CHECK edge; the calc must settle within SETTLE cycles after `btnd` falls.

## Configuration
- `CALC_PLAYER_STOP_ON_FAIL_EN` defined:
  - The first mismatch in CHECK goes straight to DONE.
  - `pass_cnt` + `fail_cnt` equals entries executed, which can be less than `len`.
- Undefined: every entry runs regardless of mismatches.

## Test plan
- Load 9 entries with ops {l,c,r}, operands and expects (3'b011, 1234→1234), (010, 0FF0→0230), (000, 324F→347F), (001, 2D31→074E), (100, FFFF→F8B1), (101, 7346→0001), (110, 0004→0010), (111, 0004→0001), (101, FFFF→0000) against a calc model; start → `done` after 1+2+9·11=102 cycles, `pass_cnt=9`, `fail_cnt=0`.
- Same program with entry 3 expect corrupted to 0000 → `fail_cnt=1`, `first_fail=3`, `pass_cnt=8`. With `CALC_PLAYER_STOP_ON_FAIL_EN`: `pass_cnt=3`, `fail_cnt=1`, `done` after 1+2+4·11 cycles.
- `start` with `len=0` → `done=1` the next cycle, `busy` never asserts, `btnu`/`btnd` stay 0.
- Pulse `start` and `load_en` at entry 1 while busy → no restart; memory unchanged; final counts match the first test.
- Assert `rst_n=0` during STROBE → `btnd`, `busy`, and the counters are 0 immediately. Release, then `start` → the full program reruns correctly, with `len` re-loaded first.
- Check waveform: `btnd` is high for exactly PULSE cycles per entry and `sw`/op are stable across every `btnd` high period.
